// File: rtl/inst_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : inst_enc_pkg
// Purpose : Shared request-op enum, FSM states, RV32I opcode/funct constants
//           and field-packing helpers for the instruction encoder.
// Revision: 1.0 - initial release
// ============================================================================
package inst_enc_pkg;

  // Symbolic request operations; codes above OP_LI are illegal.
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLL  = 5'd2,  OP_XOR  = 5'd3,
    OP_SRL  = 5'd4,  OP_SRA  = 5'd5,  OP_OR   = 5'd6,  OP_AND  = 5'd7,
    OP_ADDI = 5'd8,  OP_XORI = 5'd9,  OP_ORI  = 5'd10, OP_ANDI = 5'd11,
    OP_SLLI = 5'd12, OP_SRLI = 5'd13, OP_SRAI = 5'd14,
    OP_LW   = 5'd15, OP_JALR = 5'd16, OP_SW   = 5'd17,
    OP_BEQ  = 5'd18, OP_BNE  = 5'd19, OP_BLT  = 5'd20, OP_BGE  = 5'd21,
    OP_LUI  = 5'd22, OP_JAL  = 5'd23, OP_LI   = 5'd24
  } req_op_e;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_LI_LO = 1'b1
  } enc_state_e;

  // Major opcodes as the control decoder expects them
  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
  localparam logic [6:0] OPC_LW     = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SW     = 7'b0100011;
  localparam logic [6:0] OPC_B_TYPE = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_SW};
  endfunction

  // Branch offset bit 0 is implicitly zero, so only [12:1] is carried
  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_B_TYPE};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, OPC_LUI};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_encoder_pack.sv
`default_nettype none
// ============================================================================
// Module  : inst_pack
// Purpose : Combinational packer: symbolic op/regs/imm to one RV32I word,
//           a legal flag, and a flag telling that an LI needs a second word.
// Revision: 1.0 - initial release
// ============================================================================
module inst_pack
  import inst_enc_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal,
  output logic        li_two
);

  logic [19:0] li_hi;

  // Upper part of LI rounds up when the low 12 bits will sign-extend negative
  always_comb begin
    li_hi = imm[31:12] + {19'd0, imm[11]};
  end

  // Select the encoding for the requested op
  always_comb begin
    word   = 32'h0;
    legal  = 1'b1;
    li_two = 1'b0;
    case (op)
      OP_ADD:  word = enc_r(F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OPC_R_TYPE);
      OP_SUB:  word = enc_r(F7_ALT,  rs2, rs1, F3_ADD_SUB, rd, OPC_R_TYPE);
      OP_SLL:  word = enc_r(F7_BASE, rs2, rs1, F3_SLL,     rd, OPC_R_TYPE);
      OP_XOR:  word = enc_r(F7_BASE, rs2, rs1, F3_XOR,     rd, OPC_R_TYPE);
      OP_SRL:  word = enc_r(F7_BASE, rs2, rs1, F3_SRL_SRA, rd, OPC_R_TYPE);
      OP_SRA:  word = enc_r(F7_ALT,  rs2, rs1, F3_SRL_SRA, rd, OPC_R_TYPE);
      OP_OR:   word = enc_r(F7_BASE, rs2, rs1, F3_OR,      rd, OPC_R_TYPE);
      OP_AND:  word = enc_r(F7_BASE, rs2, rs1, F3_AND,     rd, OPC_R_TYPE);
      OP_ADDI: word = enc_i(imm[11:0], rs1, F3_ADD_SUB, rd, OPC_I_TYPE);
      OP_XORI: word = enc_i(imm[11:0], rs1, F3_XOR,     rd, OPC_I_TYPE);
      OP_ORI:  word = enc_i(imm[11:0], rs1, F3_OR,      rd, OPC_I_TYPE);
      OP_ANDI: word = enc_i(imm[11:0], rs1, F3_AND,     rd, OPC_I_TYPE);
      OP_SLLI: word = enc_r(F7_BASE, imm[4:0], rs1, F3_SLL,     rd, OPC_I_TYPE);
      OP_SRLI: word = enc_r(F7_BASE, imm[4:0], rs1, F3_SRL_SRA, rd, OPC_I_TYPE);
      OP_SRAI: word = enc_r(F7_ALT,  imm[4:0], rs1, F3_SRL_SRA, rd, OPC_I_TYPE);
      OP_LW:   word = enc_i(imm[11:0], rs1, F3_WORD,    rd, OPC_LW);
      OP_JALR: word = enc_i(imm[11:0], rs1, F3_ADD_SUB, rd, OPC_JALR);
      OP_SW:   word = enc_s(imm[11:0], rs2, rs1);
      OP_BEQ:  word = enc_b(imm[12:1], rs2, rs1, F3_BEQ);
      OP_BNE:  word = enc_b(imm[12:1], rs2, rs1, F3_BNE);
      OP_BLT:  word = enc_b(imm[12:1], rs2, rs1, F3_BLT);
      OP_BGE:  word = enc_b(imm[12:1], rs2, rs1, F3_BGE);
      OP_LUI:  word = enc_u(imm[31:12], rd);
      OP_JAL:  word = enc_j(imm[20:1], rd);
      OP_LI: begin
        // Small values fit one ADDI; otherwise LUI first, ADDI only if low bits remain
        if (li_hi == 20'd0) begin
          word = enc_i(imm[11:0], 5'd0, F3_ADD_SUB, rd, OPC_I_TYPE);
        end else begin
          word   = enc_u(li_hi, rd);
          li_two = (imm[11:0] != 12'd0);
        end
      end
      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module  : inst_encoder
// Purpose : Accepts symbolic RV32I requests, streams encoded words into the
//           IMEM write port at an auto-incrementing, loadable address.
// Revision: 1.0 - initial release
// ============================================================================
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_val,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  ill_cnt
);

  enc_state_e        state_q, state_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  ill_cnt_q, ill_cnt_d;
  logic [4:0]        li_rd_q, li_rd_d;
  logic [31:0]       li_imm_q, li_imm_d;

  logic              accept;
  logic [ADDR_W-1:0] ptr_base;
  logic [4:0]        pk_op, pk_rd, pk_rs1, pk_rs2;
  logic [31:0]       pk_imm, pk_word;
  logic              pk_legal, pk_li_two;

  // While finishing an LI the packer is reused to build ADDI rd,rd,lo
  always_comb begin
    pk_op  = req_op;
    pk_rd  = req_rd;
    pk_rs1 = req_rs1;
    pk_rs2 = req_rs2;
    pk_imm = req_imm;
    if (state_q == S_LI_LO) begin
      pk_op  = OP_ADDI;
      pk_rd  = li_rd_q;
      pk_rs1 = li_rd_q;
      pk_rs2 = 5'd0;
      pk_imm = li_imm_q;
    end
  end

  inst_pack u_pack (
    .op     (pk_op),
    .rd     (pk_rd),
    .rs1    (pk_rs1),
    .rs2    (pk_rs2),
    .imm    (pk_imm),
    .word   (pk_word),
    .legal  (pk_legal),
    .li_two (pk_li_two)
  );

  // Next-state, write, pointer and counter logic
  always_comb begin
    accept     = req_valid & ready_q;
    ptr_base   = addr_load ? addr_val : ptr_q;
    state_d    = state_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ptr_d      = ptr_base;
    err_d      = err_q;
    word_cnt_d = word_cnt_q;
    ill_cnt_d  = ill_cnt_q;
    li_rd_d    = li_rd_q;
    li_imm_d   = li_imm_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!pk_legal) begin
            err_d = 1'b1;
            if (ill_cnt_q != {CNT_W{1'b1}}) ill_cnt_d = ill_cnt_q + CNT_W'(1);
          end else begin
            we_d    = 1'b1;
            wdata_d = pk_word;
            if (pk_li_two) begin
              state_d  = S_LI_LO;
              li_rd_d  = req_rd;
              li_imm_d = req_imm;
            end
          end
        end
      end
      S_LI_LO: begin
        we_d    = 1'b1;
        wdata_d = pk_word;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (we_d) begin
      addr_d = ptr_base;
      ptr_d  = ptr_base + ADDR_W'(1);
      if (word_cnt_q != {CNT_W{1'b1}}) word_cnt_d = word_cnt_q + CNT_W'(1);
    end
    ready_d = (state_d == S_IDLE);
  end

  // All state and outputs registered; reset drops any pending ADDI
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      ptr_q      <= '0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
      ill_cnt_q  <= '0;
      li_rd_q    <= 5'd0;
      li_imm_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
      ill_cnt_q  <= ill_cnt_d;
      li_rd_q    <= li_rd_d;
      li_imm_q   <= li_imm_d;
    end
  end

  assign req_ready  = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign err        = err_q;
  assign word_cnt   = word_cnt_q;
  assign ill_cnt    = ill_cnt_q;

endmodule
`default_nettype wire
